image_fetch_ctrl: RTL and testbench

IMAGE_FETCH_CTRL -- requirements
Module: image_fetch_ctrl

---
 rtl/image_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_image_fetch_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_fetch_ctrl.sv
// Image ROM burst fetcher: issues in-order reads into a 2-entry skid FIFO
// and streams words out over a valid/ready handshake.
module image_fetch_ctrl #(
    parameter int unsigned     WIDTH = 16,
    parameter int unsigned     ADDR  = 18,
    parameter logic [ADDR-1:0] LIMIT = 18'h31000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR-1:0]  base_addr,
    input  logic [ADDR-1:0]  length,
    output logic [ADDR-1:0]  rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        ERR
    } state_t;

    localparam logic [ADDR:0] REM_ONE = {{ADDR{1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [ADDR-1:0]  addr_q, addr_d;
    logic [ADDR:0]    rem_q, rem_d;
    logic             inflight_q;
    logic             issue;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       cnt_q;

    logic             push;
    logic             pop;
    logic [2:0]       occ;
    logic [ADDR:0]    sum;
    logic             len_zero;
    logic             over;

    // A read lands in the FIFO the cycle after it is issued
    assign push = inflight_q;
    assign pop  = out_valid && out_ready;

    // Occupancy after this cycle's pop, counting the word still in flight
    assign occ = {1'b0, cnt_q}
               + {2'b00, inflight_q}
               - {2'b00, pop};

    assign sum      = {1'b0, base_addr} + {1'b0, length};
    assign len_zero = (length == '0);
    assign over     = (sum > {1'b0, LIMIT});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_zero) begin
                        done_d = 1'b1;
                    end else if (over) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = FETCH;
                        issue   = 1'b1;
                        addr_d  = base_addr;
                        rem_d   = {1'b0, length} - REM_ONE;
                    end
                end
            end
            FETCH: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else if (occ < 3'd2) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR'(1);
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && cnt_q == 2'd1 && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem[0]     <= '0;
            mem[1]     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            done_q     <= done_d;
            err_q      <= err_d;
            if (push) begin
                mem[wr_ptr_q] <= rom_data;
                wr_ptr_q      <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rom_addr  = addr_q;
    assign out_data  = mem[rd_ptr_q];
    assign out_valid = (cnt_q != 2'd0);
    assign busy      = (state_q == FETCH) || (state_q == DRAIN);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Bench for image_fetch_ctrl: ROM stub, burst runner and per-feature tests
// checked against the expected word stream ROM[base..base+len-1].
module tb_image_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] base_addr;
    logic [17:0] length;
    logic [17:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    image_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [17:0] a);
        logic [15:0] t;
        t = a[15:0] * 16'd40503;
        return t ^ {a[17:16], 14'h0} ^ 16'h3C5A;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    logic [15:0] got_q[$];
    logic [17:0] adr_q[$];
    int          adr_cyc[$];
    int first_valid, done_cyc, err_cyc, last_acc;
    int n_done, n_err, n_valid, busy_hi, busy_gap;
    int stall_bad, addr_moved, timeout;

    // Drives one start at the current negedge and observes until done + 3
    task automatic run_burst(input logic [17:0] b, input logic [17:0] len,
                             input int mode, input int extra_at);
        logic [17:0] addr0;
        logic        pv, pr, r;
        logic [15:0] pd;
        got_q.delete();
        adr_q.delete();
        adr_cyc.delete();
        first_valid = -1; done_cyc = -1; err_cyc = -1; last_acc = -1;
        n_done = 0; n_err = 0; n_valid = 0; busy_hi = 0; busy_gap = 0;
        stall_bad = 0; addr_moved = 0; timeout = 0;
        addr0     = rom_addr;
        start     = 1'b1;
        base_addr = b;
        length    = len;
        out_ready = (mode == 0);
        pv = 1'b0; pr = 1'b0; pd = '0;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            start = (k == extra_at);
            if (k == extra_at) begin
                base_addr = b + 18'd100;
                length    = 18'd3;
            end
            if (rom_addr !== addr0) addr_moved++;
            if (busy) begin
                busy_hi++;
                if (adr_q.size() == 0 || rom_addr !== adr_q[$]) begin
                    adr_q.push_back(rom_addr);
                    adr_cyc.push_back(k);
                end
            end
            if (pv && !pr && (!out_valid || out_data !== pd)) stall_bad++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (err) begin
                n_err++;
                if (err_cyc < 0) err_cyc = k;
            end
            if (done_cyc < 0 && !busy) busy_gap++;
            case (mode)
                0: r = 1'b1;
                1: r = k[0];
                2: r = ($urandom_range(0, 3) != 0);
                default: r = 1'b0;
            endcase
            out_ready = r;
            if (out_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
                if (r) begin
                    got_q.push_back(out_data);
                    last_acc = k;
                end
            end
            pv = out_valid; pr = r; pd = out_data;
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
        end
        if (done_cyc < 0) timeout = 1;
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rom_addr !== 18'h0) begin
            failures++;
            $display("FAIL reset_rom_addr got %0h want 0", rom_addr);
        end
        checks++;
        if ({out_valid, busy, done, err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got %b want 0000",
                     {out_valid, busy, done, err});
        end
        checks++;
        if (out_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_out_data got %0h want 0", out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        run_burst(18'h10, 18'd4, 0, 0);
        checks++;
        if (timeout != 0 || n_done != 1 || n_err != 0) begin
            failures++;
            $display("FAIL basic_done got to=%0d done=%0d err=%0d want 0 1 0",
                     timeout, n_done, n_err);
        end
        checks++;
        if (got_q.size() != 4 || adr_q.size() != 4) begin
            failures++;
            $display("FAIL basic_count got words=%0d addrs=%0d want 4 4",
                     got_q.size(), adr_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== rom_fn(18'h10 + 18'(i))) begin
                failures++;
                $display("FAIL basic_word%0d got %0h want %0h",
                         i, got_q[i], rom_fn(18'h10 + 18'(i)));
            end
        end
        for (int i = 0; i < 4 && i < adr_q.size(); i++) begin
            checks++;
            if (adr_q[i] !== 18'h10 + 18'(i) || adr_cyc[i] != i + 1) begin
                failures++;
                $display("FAIL basic_addr%0d got %0h@%0d want %0h@%0d",
                         i, adr_q[i], adr_cyc[i], 18'h10 + 18'(i), i + 1);
            end
        end
        checks++;
        if (first_valid != 2 || last_acc != 5) begin
            failures++;
            $display("FAIL basic_timing got first=%0d last=%0d want 2 5",
                     first_valid, last_acc);
        end
        checks++;
        if (done_cyc != last_acc + 1 || busy_gap != 0) begin
            failures++;
            $display("FAIL basic_done_cyc got %0d gap=%0d want %0d gap=0",
                     done_cyc, busy_gap, last_acc + 1);
        end
    endtask

    task automatic test_stall;
        run_burst(18'h0FFFE, 18'd4, 1, 0);
        checks++;
        if (timeout != 0 || n_done != 1 || got_q.size() != 4) begin
            failures++;
            $display("FAIL stall_count got to=%0d done=%0d words=%0d want 0 1 4",
                     timeout, n_done, got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== rom_fn(18'h0FFFE + 18'(i))) begin
                failures++;
                $display("FAIL stall_word%0d got %0h want %0h",
                         i, got_q[i], rom_fn(18'h0FFFE + 18'(i)));
            end
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL stall_stable got %0d unstable cycles want 0",
                     stall_bad);
        end
        checks++;
        if (done_cyc != last_acc + 1) begin
            failures++;
            $display("FAIL stall_done_cyc got %0d want %0d",
                     done_cyc, last_acc + 1);
        end
    endtask

    task automatic test_boundary;
        run_burst(18'h30FFC, 18'd4, 0, 0);
        checks++;
        if (timeout != 0 || n_err != 0 || got_q.size() != 4) begin
            failures++;
            $display("FAIL edge_ok got to=%0d err=%0d words=%0d want 0 0 4",
                     timeout, n_err, got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== rom_fn(18'h30FFC + 18'(i))) begin
                failures++;
                $display("FAIL edge_word%0d got %0h want %0h",
                         i, got_q[i], rom_fn(18'h30FFC + 18'(i)));
            end
        end
        run_burst(18'h30FFD, 18'd4, 0, 0);
        checks++;
        if (n_done != 1 || n_err != 1 || done_cyc != 1 || err_cyc != 1) begin
            failures++;
            $display("FAIL edge_err got done=%0d@%0d err=%0d@%0d want 1@1 1@1",
                     n_done, done_cyc, n_err, err_cyc);
        end
        checks++;
        if (addr_moved != 0 || busy_hi != 0 || n_valid != 0) begin
            failures++;
            $display("FAIL edge_err_quiet got moved=%0d busy=%0d valid=%0d want 0 0 0",
                     addr_moved, busy_hi, n_valid);
        end
        run_burst(18'h20000, 18'h30000, 0, 0);
        checks++;
        if (n_err != 1 || busy_hi != 0 || addr_moved != 0) begin
            failures++;
            $display("FAIL wide_sum_err got err=%0d busy=%0d moved=%0d want 1 0 0",
                     n_err, busy_hi, addr_moved);
        end
    endtask

    task automatic test_zero_len;
        run_burst(18'h00123, 18'd0, 0, 0);
        checks++;
        if (n_done != 1 || done_cyc != 1 || n_err != 0) begin
            failures++;
            $display("FAIL zero_done got done=%0d@%0d err=%0d want 1@1 0",
                     n_done, done_cyc, n_err);
        end
        checks++;
        if (n_valid != 0 || busy_hi != 0 || addr_moved != 0) begin
            failures++;
            $display("FAIL zero_quiet got valid=%0d busy=%0d moved=%0d want 0 0 0",
                     n_valid, busy_hi, addr_moved);
        end
    endtask

    task automatic test_reset_mid;
        logic [17:0] b;
        b = 18'($urandom_range(0, 'h30000));
        start = 1'b1; base_addr = b; length = 18'd8; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_addr !== 18'h0 || out_data !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_data got addr=%0h data=%0h want 0 0",
                     rom_addr, out_data);
        end
        checks++;
        if ({out_valid, busy, done, err} !== 4'b0) begin
            failures++;
            $display("FAIL rst_mid_flags got %b want 0000",
                     {out_valid, busy, done, err});
        end
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after got valid=%b done=%b want 0 0",
                     out_valid, done);
        end
        b = 18'($urandom_range(0, 'h30000));
        run_burst(b, 18'd5, 2, 0);
        checks++;
        if (timeout != 0 || n_done != 1 || got_q.size() != 5) begin
            failures++;
            $display("FAIL rst_mid_next got to=%0d done=%0d words=%0d want 0 1 5",
                     timeout, n_done, got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== rom_fn(b + 18'(i))) begin
                failures++;
                $display("FAIL rst_mid_word%0d got %0h want %0h",
                         i, got_q[i], rom_fn(b + 18'(i)));
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [17:0] b;
        b = 18'($urandom_range(0, 'h30000));
        run_burst(b, 18'd6, 2, 3);
        checks++;
        if (timeout != 0 || n_done != 1 || n_err != 0 || got_q.size() != 6) begin
            failures++;
            $display("FAIL ignore_count got to=%0d done=%0d err=%0d words=%0d want 0 1 0 6",
                     timeout, n_done, n_err, got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== rom_fn(b + 18'(i))) begin
                failures++;
                $display("FAIL ignore_word%0d got %0h want %0h",
                         i, got_q[i], rom_fn(b + 18'(i)));
            end
        end
    endtask

    task automatic test_random;
        logic [17:0] b, len;
        int          bad;
        bit          exp_err;
        for (int n = 0; n < 24; n++) begin
            len = 18'($urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0)
                b = 18'($urandom_range('h31000 - int'(len) + 1, 'h3FFFF));
            else
                b = 18'($urandom_range(0, 'h31000 - int'(len)));
            exp_err = (int'(b) + int'(len) > 'h31000);
            run_burst(b, len, 2, 0);
            bad = 0;
            for (int i = 0; i < got_q.size() && i < int'(len); i++)
                if (got_q[i] !== rom_fn(b + 18'(i))) bad++;
            checks++;
            if (timeout != 0 || n_done != 1 || n_err != int'(exp_err)) begin
                failures++;
                $display("FAIL rand%0d_done got to=%0d done=%0d err=%0d want 0 1 %0d",
                         n, timeout, n_done, n_err, exp_err);
            end
            checks++;
            if (got_q.size() != (exp_err ? 0 : int'(len)) || bad != 0
                || stall_bad != 0) begin
                failures++;
                $display("FAIL rand%0d_stream got words=%0d bad=%0d stall=%0d base=%0h len=%0d",
                         n, got_q.size(), bad, stall_bad, b, len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_boundary();
        test_zero_len();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
